// File: rtl/s_compress_pipe_if.sv
// s_compress_pipe_if: beat, table-write and flush signals of s_compress_pipe.
//  slave  : the compressor itself.
//  master : the agent that drives beats and table writes and sinks bytes.
//  Signals:
//   in_valid/in_ready/data_in/mode : input beat handshake (mode sampled with the beat)
//   out_valid/out_ready/data_out   : output byte handshake
//   tbl_we/tbl_addr/tbl_wdata      : substitution table write port
//   clr                            : synchronous flush of in-flight beats
//   beat_cnt                       : running count of output handshakes
interface s_compress_pipe_if #(
  parameter int LANES  = 4,
  parameter int BYTE_W = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*BYTE_W-1:0]   data_in;
  logic [1:0]                mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [BYTE_W-1:0]         data_out;
  logic                      tbl_we;
  logic [BYTE_W-1:0]         tbl_addr;
  logic [BYTE_W-1:0]         tbl_wdata;
  logic                      clr;
  logic [15:0]               beat_cnt;

  modport slave (
    input  in_valid, data_in, mode, out_ready, tbl_we, tbl_addr, tbl_wdata, clr,
    output in_ready, out_valid, data_out, beat_cnt
  );

  modport master (
    output in_valid, data_in, mode, out_ready, tbl_we, tbl_addr, tbl_wdata, clr,
    input  in_ready, out_valid, data_out, beat_cnt
  );
endinterface

// File: rtl/s_compress_pipe.sv
// s_compress_pipe: folds a LANES*BYTE_W keystream word into one BYTE_W byte.
//  Two-stage pipeline with valid/ready on both sides:
//   S1 registers the lanes (substituted through T when mode is SUB_FOLD) and the mode.
//   S2 XOR-folds the lanes, applies T to the fold in FOLD_SUB, registers data_out.
//  A table write stalls the whole pipeline for that cycle; clr flushes valids.
//  Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (table back to identity)
//   bus  : s_compress_pipe_if.slave (beats, bytes, table port, clr, beat_cnt)
module s_compress_pipe #(
  parameter int LANES  = 4,
  parameter int BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  s_compress_pipe_if.slave    bus
);
  localparam int DEPTH = 1 << BYTE_W;
  localparam logic [1:0] M_SUB_FOLD = 2'd1;
  localparam logic [1:0] M_FOLD_SUB = 2'd2;

  typedef logic [BYTE_W-1:0] byte_t;

  byte_t                         tbl_q [DEPTH];
  byte_t                         tbl_d [DEPTH];
  logic                          s1_v_q, s1_v_d;
  logic [LANES-1:0][BYTE_W-1:0]  s1_lane_q, s1_lane_d;
  logic [1:0]                    s1_mode_q, s1_mode_d;
  logic                          out_valid_q, out_valid_d;
  byte_t                         data_out_q, data_out_d;
  logic [15:0]                   beat_cnt_q, beat_cnt_d;

  logic  out_fire, s2_free, in_ready, accept, s1_adv;
  byte_t fold, s2_res, lane_b;

  always_comb begin
    out_fire = out_valid_q && bus.out_ready;
    // S2 can take a new byte if empty or its current byte leaves this cycle
    s2_free  = !out_valid_q || bus.out_ready;
    in_ready = !rst && !bus.tbl_we && !bus.clr && (!s1_v_q || s2_free);
    accept   = bus.in_valid && in_ready;
    s1_adv   = s1_v_q && s2_free && !bus.tbl_we && !bus.clr;

    fold = '0;
    for (int i = 0; i < LANES; i++) fold = fold ^ s1_lane_q[i];
    // FOLD_SUB looks up at S2 time, so it sees any write that landed while in S1
    s2_res = (s1_mode_q == M_FOLD_SUB) ? tbl_q[fold] : fold;

    tbl_d = tbl_q;
    if (bus.tbl_we) tbl_d[bus.tbl_addr] = bus.tbl_wdata;

    s1_v_d      = s1_v_q;
    s1_lane_d   = s1_lane_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    beat_cnt_d  = beat_cnt_q + 16'(out_fire);
    lane_b      = '0;

    if (bus.clr) begin
      s1_v_d      = 1'b0;
      out_valid_d = 1'b0;
    end else if (bus.tbl_we) begin
      // Stall: nothing loads, but a byte taken downstream must not be re-presented
      out_valid_d = out_valid_q && !bus.out_ready;
    end else begin
      if (s1_adv) begin
        out_valid_d = 1'b1;
        data_out_d  = s2_res;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        s1_v_d    = 1'b1;
        s1_mode_d = bus.mode;
        for (int i = 0; i < LANES; i++) begin
          lane_b       = bus.data_in[i*BYTE_W +: BYTE_W];
          s1_lane_d[i] = (bus.mode == M_SUB_FOLD) ? tbl_q[lane_b] : lane_b;
        end
      end else if (s1_adv) begin
        s1_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= byte_t'(i);
      s1_v_q      <= 1'b0;
      s1_lane_q   <= '0;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      tbl_q       <= tbl_d;
      s1_v_q      <= s1_v_d;
      s1_lane_q   <= s1_lane_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.beat_cnt  = beat_cnt_q;
endmodule
